// File: rtl/ni_injector.sv
// Network-interface packet injector: serialises a descriptor (target, size) plus FIFO'd payload into router flits.
// Latency: first flit (header) on o_data one cycle after descriptor acceptance, then one flit per credited cycle.
// Backpressure: flits advance only when i_credit=1; payload input stalls via o_pld_ready when the FIFO is full.
// Optional feature: define NI_PKT_COUNT_EN to add the saturating o_pkt_count completed-packet counter.

`ifndef TAM_FLIT
`define TAM_FLIT 16
`endif

module ni_injector #(
  parameter int TAM_FLIT   = `TAM_FLIT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [TAM_FLIT-1:0] i_req_target,
  input  logic [TAM_FLIT-1:0] i_req_size,
  input  logic                i_pld_valid,
  output logic                o_pld_ready,
  input  logic [TAM_FLIT-1:0] i_pld_data,
  output logic                o_tx,
  output logic [TAM_FLIT-1:0] o_data,
  input  logic                i_credit,
  output logic                o_clk_tx,
  output logic                o_busy,
`ifdef NI_PKT_COUNT_EN
  output logic [15:0]         o_pkt_count,
`endif
  output logic                o_pkt_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]         FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]         CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [TAM_FLIT-1:0] FLIT_ONE = {{(TAM_FLIT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, HEADER, SIZE, PAYLOAD} state_t;

  state_t              state;
  logic [TAM_FLIT-1:0] target_q;
  logic [TAM_FLIT-1:0] size_q;
  logic [TAM_FLIT-1:0] remaining;

  logic [TAM_FLIT-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic xfer;

  assign o_clk_tx = i_clk;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // A word is taken only when ready is shown, so a push offered while full
  // waits a cycle even if a pop frees a slot in that same cycle.
  assign push  = i_pld_valid && !full;
  assign xfer  = o_tx && i_credit;
  assign pop   = xfer && (state == PAYLOAD);

  assign o_pld_ready = !full;
  assign o_req_ready = (state == IDLE);
  assign o_busy      = (state != IDLE);

  // Flit lane driven from the state register and FIFO head; nothing changes without a transfer.
  always_comb begin
    o_tx       = 1'b0;
    o_data     = '0;
    o_pkt_done = 1'b0;
    case (state)
      HEADER: begin
        o_tx   = 1'b1;
        o_data = target_q;
      end
      SIZE: begin
        o_tx       = 1'b1;
        o_data     = size_q;
        o_pkt_done = i_credit && (size_q == '0);
      end
      PAYLOAD: begin
        o_tx       = !empty;
        o_data     = mem[rd_ptr];
        o_pkt_done = xfer && (remaining == FLIT_ONE);
      end
      default: begin
        o_tx   = 1'b0;
        o_data = '0;
      end
    endcase
  end

  // Packet sequencer: IDLE -> HEADER -> SIZE -> (PAYLOAD) -> IDLE, each step on a credited transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      target_q  <= '0;
      size_q    <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            target_q <= i_req_target;
            size_q   <= i_req_size;
            state    <= HEADER;
          end
        end
        HEADER: begin
          if (xfer) state <= SIZE;
        end
        SIZE: begin
          if (xfer) begin
            if (size_q != '0) begin
              remaining <= size_q;
              state     <= PAYLOAD;
            end else begin
              state <= IDLE;
            end
          end
        end
        PAYLOAD: begin
          if (pop) begin
            remaining <= remaining - FLIT_ONE;
            if (remaining == FLIT_ONE) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Payload storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_pld_data;
  end

`ifdef NI_PKT_COUNT_EN
  logic [15:0] pkt_count_q;

  // Completed-packet counter, sticks at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pkt_count_q <= '0;
    end else if (o_pkt_done && (pkt_count_q != 16'hFFFF)) begin
      pkt_count_q <= pkt_count_q + 16'd1;
    end
  end

  assign o_pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_ni_injector.sv
// Self-checking bench for ni_injector: cycle table for the main packet flows plus
// hand-written sequences for FIFO-full wrap, mid-packet reset and the optional packet counter.
module tb_ni_injector;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [15:0] i_req_target;
  logic [15:0] i_req_size;
  logic        i_pld_valid;
  logic        o_pld_ready;
  logic [15:0] i_pld_data;
  logic        o_tx;
  logic [15:0] o_data;
  logic        i_credit;
  logic        o_clk_tx;
  logic        o_busy;
  logic        o_pkt_done;
`ifdef NI_PKT_COUNT_EN
  logic [15:0] o_pkt_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  ni_injector #(.TAM_FLIT(16), .FIFO_DEPTH(8)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_target (i_req_target),
    .i_req_size   (i_req_size),
    .i_pld_valid  (i_pld_valid),
    .o_pld_ready  (o_pld_ready),
    .i_pld_data   (i_pld_data),
    .o_tx         (o_tx),
    .o_data       (o_data),
    .i_credit     (i_credit),
    .o_clk_tx     (o_clk_tx),
    .o_busy       (o_busy),
`ifdef NI_PKT_COUNT_EN
    .o_pkt_count  (o_pkt_count),
`endif
    .o_pkt_done   (o_pkt_done)
  );

  typedef struct {
    logic        req_valid;
    logic [15:0] target;
    logic [15:0] size;
    logic        pld_valid;
    logic [15:0] pld_data;
    logic        credit;
    logic        exp_tx;
    logic [15:0] exp_data;
    logic        exp_done;
    logic        exp_req_ready;
    logic        exp_busy;
  } vec_t;

  localparam logic [15:0] WA = 16'hAAA1;
  localparam logic [15:0] WB = 16'hBBB2;
  localparam logic [15:0] WC = 16'hCCC3;
  localparam logic [15:0] WD = 16'hDDD4;
  localparam logic [15:0] WE = 16'hEEE5;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Next cycle: wait for the edge, then settle 1 time unit before driving.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst        = 1'b1;
    i_req_valid  = 1'b0;
    i_req_target = '0;
    i_req_size   = '0;
    i_pld_valid  = 1'b0;
    i_pld_data   = '0;
    i_credit     = 1'b0;
    cyc();
    cyc();
    i_rst = 1'b0;
  endtask

  task automatic push(input logic [15:0] w);
    i_pld_valid = 1'b1;
    i_pld_data  = w;
    cyc();
    i_pld_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic rv, input logic [15:0] t, input logic [15:0] s,
                              input logic pv, input logic [15:0] pd, input logic cr,
                              input logic etx, input logic [15:0] ed, input logic edn,
                              input logic err, input logic eb);
    vec_t v;
    v.req_valid = rv; v.target = t; v.size = s; v.pld_valid = pv; v.pld_data = pd;
    v.credit = cr; v.exp_tx = etx; v.exp_data = ed; v.exp_done = edn;
    v.exp_req_ready = err; v.exp_busy = eb;
    return v;
  endfunction

  // Sends a size=0 packet and waits (bounded) for its done pulse.
  task automatic send_zero(input logic [15:0] t, input string name);
    bit got = 0;
    i_req_valid  = 1'b1;
    i_req_target = t;
    i_req_size   = 16'h0000;
    i_credit     = 1'b1;
    cyc();
    i_req_valid = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      #1;
      if (o_pkt_done) got = 1;
      cyc();
    end
    chk({name, "_done_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    bit          done_seen;
    bit          pushed;
    bit          acc;

    // Cycle table: size=3 packet, size=0 packet, size=1 packet with a 4-cycle credit stall in SIZE.
    vt[0]  = mk(1, 16'h0011, 16'd3, 0, 16'h0, 1,  0, 16'h0000, 0, 1, 0);
    vt[1]  = mk(0, 16'h0000, 16'd0, 0, 16'h0, 1,  1, 16'h0011, 0, 0, 1);
    vt[2]  = mk(0, 16'h0000, 16'd0, 0, 16'h0, 1,  1, 16'h0003, 0, 0, 1);
    vt[3]  = mk(0, 16'h0000, 16'd0, 0, 16'h0, 1,  1, WA,       0, 0, 1);
    vt[4]  = mk(0, 16'h0000, 16'd0, 0, 16'h0, 1,  1, WB,       0, 0, 1);
    vt[5]  = mk(0, 16'h0000, 16'd0, 0, 16'h0, 1,  1, WC,       1, 0, 1);
    vt[6]  = mk(1, 16'h0022, 16'd0, 0, 16'h0, 1,  0, 16'h0000, 0, 1, 0);
    vt[7]  = mk(0, 16'h0000, 16'd0, 0, 16'h0, 1,  1, 16'h0022, 0, 0, 1);
    vt[8]  = mk(0, 16'h0000, 16'd0, 0, 16'h0, 1,  1, 16'h0000, 1, 0, 1);
    vt[9]  = mk(1, 16'h0033, 16'd1, 1, WD,    1,  0, 16'h0000, 0, 1, 0);
    vt[10] = mk(0, 16'h0000, 16'd0, 0, 16'h0, 1,  1, 16'h0033, 0, 0, 1);
    vt[11] = mk(0, 16'h0000, 16'd0, 0, 16'h0, 0,  1, 16'h0001, 0, 0, 1);
    vt[12] = mk(0, 16'h0000, 16'd0, 0, 16'h0, 0,  1, 16'h0001, 0, 0, 1);
    vt[13] = mk(0, 16'h0000, 16'd0, 0, 16'h0, 0,  1, 16'h0001, 0, 0, 1);
    vt[14] = mk(0, 16'h0000, 16'd0, 0, 16'h0, 0,  1, 16'h0001, 0, 0, 1);
    vt[15] = mk(0, 16'h0000, 16'd0, 0, 16'h0, 1,  1, 16'h0001, 0, 0, 1);
    vt[16] = mk(0, 16'h0000, 16'd0, 0, 16'h0, 1,  1, WD,       1, 0, 1);
    vt[17] = mk(0, 16'h0000, 16'd0, 0, 16'h0, 1,  0, 16'h0000, 0, 1, 0);

    // Reset state
    do_reset();
    #1;
    chk("rst_tx",        32'(o_tx),        32'd0);
    chk("rst_data",      32'(o_data),      32'd0);
    chk("rst_req_ready", 32'(o_req_ready), 32'd1);
    chk("rst_busy",      32'(o_busy),      32'd0);
    chk("rst_done",      32'(o_pkt_done),  32'd0);
    chk("rst_pld_ready", 32'(o_pld_ready), 32'd1);
    chk("clk_tx_follows",32'(o_clk_tx),    32'(i_clk));

    // Preload A,B,C then run the table
    push(WA);
    push(WB);
    push(WC);
    for (int i = 0; i < 18; i++) begin
      i_req_valid  = vt[i].req_valid;
      i_req_target = vt[i].target;
      i_req_size   = vt[i].size;
      i_pld_valid  = vt[i].pld_valid;
      i_pld_data   = vt[i].pld_data;
      i_credit     = vt[i].credit;
      #1;
      chk($sformatf("vec%0d_tx", i),        32'(o_tx),        32'(vt[i].exp_tx));
      chk($sformatf("vec%0d_data", i),      32'(o_data),      32'(vt[i].exp_data));
      chk($sformatf("vec%0d_done", i),      32'(o_pkt_done),  32'(vt[i].exp_done));
      chk($sformatf("vec%0d_req_ready", i), 32'(o_req_ready), 32'(vt[i].exp_req_ready));
      chk($sformatf("vec%0d_busy", i),      32'(o_busy),      32'(vt[i].exp_busy));
      cyc();
    end
    i_req_valid = 1'b0;
    i_pld_valid = 1'b0;

    // FIFO full, held push at full, then drain through a size=9 packet with pointer wrap
    do_reset();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("fill%0d_ready", i), 32'(o_pld_ready), 32'd1);
      push(16'h1000 + 16'(i));
    end
    i_pld_valid = 1'b1;
    i_pld_data  = 16'h1008;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("full_hold%0d_ready", i), 32'(o_pld_ready), 32'd0);
      cyc();
    end
    i_req_valid  = 1'b1;
    i_req_target = 16'h0044;
    i_req_size   = 16'd9;
    i_credit     = 1'b1;
    done_seen    = 0;
    for (int k = 0; k < 40 && !done_seen; k++) begin
      #1;
      if (o_tx && i_credit) got_q.push_back(o_data);
      pushed = i_pld_valid && o_pld_ready;
      acc    = i_req_valid && o_req_ready;
      if (o_pkt_done) done_seen = 1;
      cyc();
      if (pushed) i_pld_valid = 1'b0;
      if (acc)    i_req_valid = 1'b0;
    end
    chk("wrap_done_seen", 32'(done_seen), 32'd1);
    chk("wrap_held_word_taken", 32'(i_pld_valid), 32'd0);
    exp_q.push_back(16'h0044);
    exp_q.push_back(16'd9);
    for (int i = 0; i < 9; i++) exp_q.push_back(16'h1000 + 16'(i));
    chk("wrap_flit_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("wrap_flit%0d", i), 32'(got_q[i]), 32'(exp_q[i]));

    // Reset after the 2nd payload of a size=5 packet, then a clean packet on an empty FIFO
    do_reset();
    for (int i = 0; i < 5; i++) push(16'h2000 + 16'(i));
    i_req_valid  = 1'b1;
    i_req_target = 16'h0055;
    i_req_size   = 16'd5;
    i_credit     = 1'b1;
    cyc();
    i_req_valid = 1'b0;
    exp_q = {16'h0055, 16'h0005, 16'h2000, 16'h2001};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("abort_flit%0d", i), 32'(o_data), 32'(exp_q[i]));
      cyc();
    end
    i_rst = 1'b1;
    cyc();
    i_rst = 1'b0;
    #1;
    chk("abort_tx",        32'(o_tx),        32'd0);
    chk("abort_busy",      32'(o_busy),      32'd0);
    chk("abort_req_ready", 32'(o_req_ready), 32'd1);
    chk("abort_data",      32'(o_data),      32'd0);
    i_req_valid  = 1'b1;
    i_req_target = 16'h0066;
    i_req_size   = 16'd1;
    cyc();
    i_req_valid = 1'b0;
    #1;
    chk("post_hdr", 32'(o_data), 32'h0066);
    cyc();
    #1;
    chk("post_size", 32'(o_data), 32'h0001);
    cyc();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("post_empty%0d_tx", i), 32'(o_tx), 32'd0);
      cyc();
    end
    push(WE);
    #1;
    chk("post_pld_tx",   32'(o_tx),       32'd1);
    chk("post_pld_data", 32'(o_data),     32'(WE));
    chk("post_pld_done", 32'(o_pkt_done), 32'd1);
    cyc();
    #1;
    chk("post_idle_busy", 32'(o_busy), 32'd0);

`ifdef NI_PKT_COUNT_EN
    do_reset();
    #1;
    chk("cnt_reset", 32'(o_pkt_count), 32'd0);
    send_zero(16'h0071, "cnt_p1");
    send_zero(16'h0072, "cnt_p2");
    send_zero(16'h0073, "cnt_p3");
    #1;
    chk("cnt_three", 32'(o_pkt_count), 32'd3);
    force dut.pkt_count_q = 16'hFFFF;
    cyc();
    release dut.pkt_count_q;
    send_zero(16'h0074, "cnt_sat");
    #1;
    chk("cnt_saturated", 32'(o_pkt_count), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
